fetch_fifo: RTL

Elastic buffer between the instruction-fetch stage and the ID stage. Stores fetch entries (address, instruction, branch prediction, exception) produced by IF and presents them in order to ID's realigner. The ID side uses a valid/ack handshake. The block decouples I-cache return timing from decode stalls. A flush empties the buffer so that a redirected fetch stream starts clean.

---
 rtl/fetch_fifo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - elastic in-order buffer of fetch entries between IF and ID
package fetch_fifo_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] predict_address;
  } branchpredict_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  cause;
    logic [31:0] tval;
  } exception_t;

  typedef struct packed {
    logic [31:0]    address;
    logic [31:0]    instruction;
    branchpredict_t bp;
    exception_t     ex;
  } fetch_entry_t;

endpackage

module fetch_fifo
  import fetch_fifo_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int ALMOST_FULL_TH = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  fetch_entry_t                 fetch_entry_i,
  input  logic                         fetch_entry_valid_i,
  output logic                         fetch_ready_o,
  output logic                         almost_full_o,
  output fetch_entry_t                 fetch_entry_o,
  output logic                         fetch_entry_valid_o,
  input  logic                         fetch_ack_i,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(ALMOST_FULL_TH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;

  logic push;
  logic pop;

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign fetch_ready_o       = (cnt < CNT_FULL);
  assign fetch_entry_valid_o = (cnt != '0);
  assign almost_full_o       = (cnt >= CNT_AF);
  assign occupancy_o         = cnt;
  assign fetch_entry_o       = mem[rd_ptr];

  assign push = fetch_entry_valid_i && fetch_ready_o && !flush_i;
  assign pop  = fetch_ack_i && fetch_entry_valid_o && !flush_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= fetch_entry_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

`ifndef SYNTHESIS
  // IF must keep offering an entry once it has been held off by a full buffer.
  logic held_off;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      held_off <= 1'b0;
    end else begin
      assert (cnt <= CNT_FULL)
        else $error("fetch_fifo: count exceeds depth");
      if (held_off && !flush_i) begin
        assert (fetch_entry_valid_i)
          else $error("fetch_fifo: entry withdrawn while held off");
      end
      held_off <= fetch_entry_valid_i && !fetch_ready_o && !flush_i;
    end
  end
`endif

endmodule
